// File: rtl/motor_mix_pkg.sv
// Shared FSM type, default gains and arithmetic helpers for the motor mixer / speed controller.
package motor_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MIX,
        ST_TRACK
    } state_e;

    localparam int DEF_BASE_RPM   = 4000;
    localparam int DEF_ALT_GAIN   = 512;
    localparam int DEF_DIR_GAIN   = 256;
    localparam int DEF_STEP_SHIFT = 2;
    localparam int DEF_TOL        = 16;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_MAX_STEP   = 1024;

    // Odd channels take negative roll; channels 2,3 (mod 4) take negative pitch.
    function automatic int sx(input int i);
        return (i % 2 == 1) ? -1 : 1;
    endfunction

    function automatic int sy(input int i);
        return ((i / 2) % 2 == 1) ? -1 : 1;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w-1].
    function automatic logic [31:0] sat_u(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< w) - 32'sd1;
        if (v < 0) return '0;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/mot_track_step.sv
// One-channel proportional correction step: error, deadband, delta and saturation.
// MOT_RATE_LIMIT_EN clamps the delta to +/-MAX_STEP before saturation.
module mot_track_step
    import motor_mix_pkg::*;
#(
    parameter int RPM_W      = 16,
    parameter int SET_W      = 16,
    parameter int STEP_SHIFT = DEF_STEP_SHIFT,
    parameter int TOL        = DEF_TOL
`ifdef MOT_RATE_LIMIT_EN
    ,
    parameter int MAX_STEP   = DEF_MAX_STEP
`endif
) (
    input  logic [SET_W-1:0]        target_i,
    input  logic signed [RPM_W-1:0] sense_i,
    input  logic [SET_W-1:0]        cur_set_i,
    output logic                    in_tol_o,
    output logic [SET_W-1:0]        next_set_o
);
    localparam int ERR_W = RPM_W + 2;
    localparam logic signed [ERR_W-1:0] TOL_E = ERR_W'(TOL);

    logic signed [ERR_W-1:0] err, err_abs, delta;
    logic signed [31:0]      delta_lim, sum;

    always_comb begin
        err       = $signed(ERR_W'(target_i)) - ERR_W'(sense_i);
        err_abs   = err[ERR_W-1] ? -err : err;
        in_tol_o  = (err_abs <= TOL_E);
        delta     = err >>> STEP_SHIFT;
        delta_lim = {{(32-ERR_W){delta[ERR_W-1]}}, delta};
`ifdef MOT_RATE_LIMIT_EN
        if (delta_lim > MAX_STEP) begin
            delta_lim = MAX_STEP;
        end else if (delta_lim < -MAX_STEP) begin
            delta_lim = -MAX_STEP;
        end
`endif
        sum        = $signed({{(32-SET_W){1'b0}}, cur_set_i}) + delta_lim;
        next_set_o = in_tol_o ? cur_set_i : SET_W'(sat_u(sum, SET_W));
    end

endmodule

// File: rtl/motor_mix_ctrl.sv
// Command mixer and round-robin closed-loop speed controller for NUM_MOT motors.
// Optional build macro MOT_RATE_LIMIT_EN limits each setpoint correction to +/-MAX_STEP.
module motor_mix_ctrl
    import motor_mix_pkg::*;
#(
    parameter int NUM_MOT    = 4,
    parameter int CMD_W      = 3,
    parameter int RPM_W      = 16,
    parameter int SET_W      = 16,
    parameter int BASE_RPM   = DEF_BASE_RPM,
    parameter int ALT_GAIN   = DEF_ALT_GAIN,
    parameter int DIR_GAIN   = DEF_DIR_GAIN,
    parameter int STEP_SHIFT = DEF_STEP_SHIFT,
    parameter int TOL        = DEF_TOL,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int MAX_STEP   = DEF_MAX_STEP
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic signed [CMD_W-1:0]  altcmd,
    input  logic signed [CMD_W-1:0]  dircmd_x,
    input  logic signed [CMD_W-1:0]  dircmd_y,
    input  logic [NUM_MOT*RPM_W-1:0] rpm_sense,
    output logic [NUM_MOT*SET_W-1:0] mot_set,
    output logic                     settled,
    output logic                     busy
);
    localparam int IDX_W = $clog2(NUM_MOT);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int MIX_W = RPM_W + 4;

    if (!(NUM_MOT == 4 || NUM_MOT == 8) || MAX_STEP < 1) begin : g_param_check
        $error("motor_mix_ctrl: NUM_MOT must be 4 or 8 and MAX_STEP positive");
    end

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [CMD_W-1:0] alt_q, alt_d, dx_q, dx_d, dy_q, dy_d;
    logic [SET_W-1:0]        target_q [NUM_MOT];
    logic [SET_W-1:0]        target_d [NUM_MOT];
    logic [SET_W-1:0]        set_q [NUM_MOT];
    logic [SET_W-1:0]        set_d [NUM_MOT];
    logic [NUM_MOT-1:0]      in_tol_q, in_tol_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    settled_q, settled_d;

    logic signed [RPM_W-1:0] sense_a [NUM_MOT];
    logic signed [MIX_W-1:0] mix_val;
    logic [SET_W-1:0]        mix_target, step_set;
    logic                    step_in_tol, accept;

    for (genvar g = 0; g < NUM_MOT; g++) begin : g_chan
        assign sense_a[g]                = rpm_sense[g*RPM_W +: RPM_W];
        assign mot_set[g*SET_W +: SET_W] = set_q[g];
    end

    assign cmd_ready = (state_q != ST_MIX);
    assign busy      = (state_q != ST_IDLE);
    assign settled   = settled_q;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        mix_val = MIX_W'(BASE_RPM)
                + MIX_W'(alt_q) * MIX_W'(ALT_GAIN)
                + MIX_W'(sx(int'(idx_q))) * MIX_W'(dx_q) * MIX_W'(DIR_GAIN)
                + MIX_W'(sy(int'(idx_q))) * MIX_W'(dy_q) * MIX_W'(DIR_GAIN);
        mix_target = SET_W'(sat_u({{(32-MIX_W){mix_val[MIX_W-1]}}, mix_val}, SET_W));
    end

    // A single step unit is time-shared across channels by idx_q.
    mot_track_step #(
        .RPM_W      (RPM_W),
        .SET_W      (SET_W),
        .STEP_SHIFT (STEP_SHIFT),
        .TOL        (TOL)
`ifdef MOT_RATE_LIMIT_EN
        ,
        .MAX_STEP   (MAX_STEP)
`endif
    ) u_step (
        .target_i   (target_q[idx_q]),
        .sense_i    (sense_a[idx_q]),
        .cur_set_i  (set_q[idx_q]),
        .in_tol_o   (step_in_tol),
        .next_set_o (step_set)
    );

    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        alt_d     = alt_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        target_d  = target_q;
        set_d     = set_q;
        in_tol_d  = in_tol_q;
        cnt_d     = cnt_q;
        settled_d = settled_q;

        if (accept) begin
            alt_d   = altcmd;
            dx_d    = dircmd_x;
            dy_d    = dircmd_y;
            idx_d   = '0;
            state_d = ST_MIX;
        end

        case (state_q)
            ST_IDLE: ;
            ST_MIX: begin
                target_d[idx_q] = mix_target;
                if (idx_q == IDX_W'(NUM_MOT - 1)) begin
                    idx_d   = '0;
                    state_d = ST_TRACK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_TRACK: begin
                if (accept) begin
                    in_tol_d  = '0;
                    cnt_d     = '0;
                    settled_d = 1'b0;
                end else begin
                    set_d[idx_q]    = step_set;
                    in_tol_d[idx_q] = step_in_tol;
                    idx_d = (idx_q == IDX_W'(NUM_MOT - 1)) ? '0 : idx_q + 1'b1;
                    if (&in_tol_q) begin
                        cnt_d = (cnt_q == CNT_W'(SETTLE_CYC)) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                    settled_d = (cnt_d == CNT_W'(SETTLE_CYC));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: targets and setpoints are plain registers with reset, so an abort leaves no stale channel data.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            alt_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            in_tol_q  <= '0;
            cnt_q     <= '0;
            settled_q <= 1'b0;
            for (int i = 0; i < NUM_MOT; i++) begin
                target_q[i] <= '0;
                set_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            alt_q     <= alt_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            target_q  <= target_d;
            set_q     <= set_d;
            in_tol_q  <= in_tol_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

endmodule

// File: tb/tb_motor_mix_ctrl.sv
// Self-checking bench for motor_mix_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_motor_mix_ctrl;

    localparam int NUM_MOT    = 4;
    localparam int CMD_W      = 3;
    localparam int RPM_W      = 16;
    localparam int SET_W      = 16;
    localparam int BASE_RPM   = 4000;
    localparam int ALT_GAIN   = 512;
    localparam int DIR_GAIN   = 256;
    localparam int STEP_SHIFT = 2;
    localparam int TOL        = 16;
    localparam int SETTLE_CYC = 8;
    localparam int MAX_STEP   = 1024;
    localparam int SET_MAX    = (1 << SET_W) - 1;

    logic                     clk = 1'b0;
    logic                     resetn = 1'b1;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic signed [CMD_W-1:0]  altcmd = '0;
    logic signed [CMD_W-1:0]  dircmd_x = '0;
    logic signed [CMD_W-1:0]  dircmd_y = '0;
    logic [NUM_MOT*RPM_W-1:0] rpm_sense = '0;
    logic [NUM_MOT*SET_W-1:0] mot_set;
    logic                     settled;
    logic                     busy;

    always #5 clk = ~clk;

    motor_mix_ctrl #(
        .NUM_MOT(NUM_MOT), .CMD_W(CMD_W), .RPM_W(RPM_W), .SET_W(SET_W),
        .BASE_RPM(BASE_RPM), .ALT_GAIN(ALT_GAIN), .DIR_GAIN(DIR_GAIN),
        .STEP_SHIFT(STEP_SHIFT), .TOL(TOL), .SETTLE_CYC(SETTLE_CYC), .MAX_STEP(MAX_STEP)
    ) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .altcmd(altcmd), .dircmd_x(dircmd_x), .dircmd_y(dircmd_y),
        .rpm_sense(rpm_sense), .mot_set(mot_set), .settled(settled), .busy(busy)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: m_since counts edges since the last accepted command (-1 = idle).
    // Edges 1..NUM_MOT after acceptance mix one target each; afterwards channels are corrected in turn.
    int m_tgt [NUM_MOT];
    int m_set [NUM_MOT];
    int m_since;
    int m_alt, m_dx, m_dy;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_set(input int v);
        if (v < 0) return 0;
        if (v > SET_MAX) return SET_MAX;
        return v;
    endfunction

    function automatic int mix_target(input int ch);
        int sgn_x, sgn_y;
        sgn_x = (ch % 2 == 1) ? -1 : 1;
        sgn_y = ((ch / 2) % 2 == 1) ? -1 : 1;
        return clamp_set(BASE_RPM + m_alt * ALT_GAIN + sgn_x * m_dx * DIR_GAIN + sgn_y * m_dy * DIR_GAIN);
    endfunction

    function automatic int sense_of(input int ch);
        logic signed [RPM_W-1:0] s;
        s = rpm_sense[ch*RPM_W +: RPM_W];
        return int'(s);
    endfunction

    function automatic int set_of(input int ch);
        return int'(mot_set[ch*SET_W +: SET_W]);
    endfunction

    function automatic logic [NUM_MOT*SET_W-1:0] pack_model();
        logic [NUM_MOT*SET_W-1:0] p;
        for (int i = 0; i < NUM_MOT; i++) p[i*SET_W +: SET_W] = SET_W'(m_set[i]);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_MOT; i++) begin
            m_tgt[i] = 0;
            m_set[i] = 0;
        end
        m_since = -1;
        m_alt = 0; m_dx = 0; m_dy = 0;
    endtask

    task automatic model_edge();
        int ch, e, d;
        if ((m_since < 0 || m_since >= NUM_MOT) && cmd_valid) begin
            m_alt   = int'(altcmd);
            m_dx    = int'(dircmd_x);
            m_dy    = int'(dircmd_y);
            m_since = 0;
        end else if (m_since >= 0 && m_since < NUM_MOT) begin
            m_tgt[m_since] = mix_target(m_since);
            m_since++;
        end else if (m_since >= NUM_MOT) begin
            ch = (m_since - NUM_MOT) % NUM_MOT;
            e  = m_tgt[ch] - sense_of(ch);
            if (e > TOL || e < -TOL) begin
                d = e >>> STEP_SHIFT;
`ifdef MOT_RATE_LIMIT_EN
                if (d > MAX_STEP) d = MAX_STEP;
                if (d < -MAX_STEP) d = -MAX_STEP;
`endif
                m_set[ch] = clamp_set(m_set[ch] + d);
            end
            m_since++;
            if (m_since >= 2 * NUM_MOT) m_since -= NUM_MOT;
        end
    endtask

    task automatic step();
        check("cmd_ready", cmd_ready, (m_since < 0 || m_since >= NUM_MOT));
        model_edge();
        @(posedge clk);
        #1;
        check("mot_set", mot_set, pack_model());
        check("busy", busy, (m_since >= 0));
    endtask

    task automatic send_cmd(input int a, input int x, input int y);
        cmd_valid = 1'b1;
        altcmd    = CMD_W'(a);
        dircmd_x  = CMD_W'(x);
        dircmd_y  = CMD_W'(y);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic loopback();
        for (int i = 0; i < NUM_MOT; i++) rpm_sense[i*RPM_W +: RPM_W] = mot_set[i*SET_W +: SET_W];
    endtask

    task automatic set_all_sense(input logic [RPM_W-1:0] v);
        for (int i = 0; i < NUM_MOT; i++) rpm_sense[i*RPM_W +: RPM_W] = v;
    endtask

    task automatic settle_loop(input string tag, input int budget);
        for (int n = 0; n < budget && !settled; n++) begin
            loopback();
            step();
        end
        check(tag, settled, 1'b1);
    endtask

    task automatic check_near(input string tag, input int ch, input int exp);
        int d;
        d = set_of(ch) - exp;
        check(tag, (d <= TOL && d >= -TOL), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_MOT*SET_W-1:0] prev;
        int t3 [NUM_MOT];

        // Reset held for three cycles
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mot_set", mot_set, '0);
        check("rst_settled", settled, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        @(negedge clk);
        resetn = 1'b0;

        // Altitude command with zero feedback: first correction lands NUM_MOT+1 edges after acceptance
        set_all_sense('0);
        send_cmd(1, 0, 0);
        for (int i = 0; i < NUM_MOT; i++) begin
            check("t2_ready_low", cmd_ready, 1'b0);
            step();
        end
        check("t2_ready_track", cmd_ready, 1'b1);
        check("t2_set_before", mot_set, '0);
        step();
        check("t2_set0", set_of(0), 1128);
        check("t2_set1", set_of(1), 0);

        // Roll command, loopback feedback converges and settles
        t3[0] = 4256; t3[1] = 3744; t3[2] = 4256; t3[3] = 3744;
        loopback();
        send_cmd(0, 1, 0);
        settle_loop("t3_settled", 600);
        for (int i = 0; i < NUM_MOT; i++) check_near("t3_near", i, t3[i]);

        // New command while settled: settled drops on the accept edge, setpoints continuous
        prev = mot_set;
        loopback();
        send_cmd(-1, 0, 0);
        check("t5_settled_clr", settled, 1'b0);
        check("t5_continuous", mot_set, prev);
        settle_loop("t5_settled", 600);
        for (int i = 0; i < NUM_MOT; i++) check_near("t5_near", i, 3488);

        // Large negative feedback drives every setpoint to the upper rail with no wrap
        set_all_sense(16'h8000);
        send_cmd(3, 0, 0);
        repeat (300) step();
        for (int i = 0; i < NUM_MOT; i++) check("t4_sat", set_of(i), SET_MAX);
        repeat (8) step();
        for (int i = 0; i < NUM_MOT; i++) check("t4_hold", set_of(i), SET_MAX);

        // Asynchronous reset during the second mix cycle
        send_cmd(2, 1, 1);
        step();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        model_reset();
        check("t6_rst_set", mot_set, '0);
        check("t6_rst_settled", settled, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ready", cmd_ready, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        set_all_sense('0);
        send_cmd(1, 0, 0);
        repeat (NUM_MOT) step();
        step();
        check("t6_set0", set_of(0), 1128);
        for (int i = 1; i < NUM_MOT; i++) check("t6_setn", set_of(i), 0);

        // Randomized commands (including ones offered during mixing) and feedback
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0: for (int i = 0; i < NUM_MOT; i++) rpm_sense[i*RPM_W +: RPM_W] = RPM_W'($urandom);
                1: for (int i = 0; i < NUM_MOT; i++) rpm_sense[i*RPM_W +: RPM_W] = RPM_W'($urandom_range(0, 9000));
                default: loopback();
            endcase
            cmd_valid = ($urandom_range(0, 15) == 0);
            altcmd    = CMD_W'($urandom);
            dircmd_x  = CMD_W'($urandom);
            dircmd_y  = CMD_W'($urandom);
            step();
        end
        cmd_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
